// File: rtl/dam_operand_feeder.sv
// Operand sequencer for the DiffAddMul core: buffers packed operand words in a
// circular FIFO and presents one at a time from a head register, advancing on core acceptance.
module dam_operand_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [24:0]     wr_data,
  output logic            full,
  output logic [AW+1:0]   count,
  output logic            overflow,
  input  logic            core_in_valid,
  output logic [7:0]      i,
  output logic [7:0]      j,
  output logic [7:0]      k,
  output logic            operation,
  output logic            present,
  output logic            underrun,
  output logic [15:0]     issued
);

  localparam int unsigned OW = AW + 1;
  localparam int unsigned CW = AW + 2;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] k;
    logic       op;
  } word_t;

  localparam word_t IDLE_WORD = '{i: 8'h00, j: 8'h00, k: 8'h00, op: 1'b1};

  word_t         mem [DEPTH];
  word_t         head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;

  logic          do_write;
  logic          do_drop;
  logic          retire;
  logic          starve;
  logic          head_free;
  logic          do_load;
  logic [OW-1:0] occ_nxt;
  logic          present_nxt;
  logic [CW-1:0] count_nxt;

  // Event decode, all evaluated on pre-edge state so full-drop ignores a same-edge load.
  always_comb begin
    do_write    = 1'b0;
    do_drop     = 1'b0;
    retire      = 1'b0;
    starve      = 1'b0;
    head_free   = 1'b0;
    do_load     = 1'b0;
    occ_nxt     = occ;
    present_nxt = present;
    count_nxt   = '0;

    do_write  = wr_en && (occ != OCC_FULL);
    do_drop   = wr_en && (occ == OCC_FULL);
    retire    = core_in_valid && present;
    starve    = core_in_valid && !present;
    head_free = !present || retire;
    do_load   = head_free && (occ != '0);

    occ_nxt     = occ + OW'(do_write) - OW'(do_load);
    present_nxt = do_load || (present && !retire);
    count_nxt   = CW'(occ_nxt) + CW'(present_nxt);
  end

  // Storage array needs no reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= word_t'(wr_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      head     <= IDLE_WORD;
      present  <= 1'b0;
      full     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
      issued   <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_load) begin
        head   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end else if (retire) begin
        head <= IDLE_WORD;
      end
      if (retire) begin
        issued <= issued + 16'd1;
      end
      if (do_drop) begin
        overflow <= 1'b1;
      end
      if (starve) begin
        underrun <= 1'b1;
      end
      occ     <= occ_nxt;
      present <= present_nxt;
      full    <= (occ_nxt == OCC_FULL);
      count   <= count_nxt;
    end
  end

  assign i         = head.i;
  assign j         = head.j;
  assign k         = head.k;
  assign operation = head.op;

endmodule

// File: tb/tb_dam_operand_feeder.sv
// Randomized scoreboard bench for dam_operand_feeder against a queue-based reference model.
module tb_dam_operand_feeder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [24:0]   wr_data;
  logic          full;
  logic [AW+1:0] count;
  logic          overflow;
  logic          core_in_valid;
  logic [7:0]    i, j, k;
  logic          operation;
  logic          present;
  logic          underrun;
  logic [15:0]   issued;

  int errors = 0;
  int checks = 0;

  dam_operand_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .overflow(overflow),
    .core_in_valid(core_in_valid), .i(i), .j(j), .k(k),
    .operation(operation), .present(present), .underrun(underrun),
    .issued(issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words queue in sb until the core takes them.
  logic [24:0] sb [$];
  int  m_occ, m_issued;
  bit  m_present, m_over, m_under, armed;
  bit  t_wr_ok, t_ret, t_load;

  always @(posedge clk) begin
    if (rst) begin
      m_occ = 0; m_present = 0; m_issued = 0; m_over = 0; m_under = 0;
      sb.delete();
      armed = 1;
    end else if (armed) begin
      t_wr_ok = wr_en && (m_occ < DEPTH);
      t_ret   = core_in_valid && m_present;
      t_load  = (!m_present || t_ret) && (m_occ > 0);
      if (wr_en && !t_wr_ok) m_over = 1;
      if (core_in_valid && !m_present) m_under = 1;
      if (t_ret) m_issued++;
      if (t_wr_ok) sb.push_back(wr_data);
      m_occ     = m_occ + int'(t_wr_ok) - int'(t_load);
      m_present = t_load || (m_present && !t_ret);
    end
  end

  // Monitor: compare status every cycle; pop and compare the word the core takes.
  logic [24:0] exp_w;
  always @(negedge clk) begin
    if (armed) begin
      chk("present", present, m_present);
      chk("count", count, m_occ + int'(m_present));
      chk("full", full, (m_occ == DEPTH));
      chk("overflow", overflow, m_over);
      chk("underrun", underrun, m_under);
      chk("issued", issued, m_issued[15:0]);
      if (!m_present) begin
        chk("idle_word", {i, j, k, operation}, 25'h0000001);
      end else if (core_in_valid && !rst) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          exp_w = sb.pop_front();
          chk("word", {i, j, k, operation}, exp_w);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; core_in_valid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; core_in_valid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_operation", operation, 1);
    chk("rst_present", present, 0);
    chk("rst_issued", issued, 0);

    // Single word: two-edge latency, then retire to idle
    wr_en = 1'b1; wr_data = 25'h1FFFFFF;
    cyc();
    wr_en = 1'b0;
    cyc();
    chk("single_i", i, 8'hFF);
    chk("single_j", j, 8'hFF);
    chk("single_k", k, 8'hFF);
    chk("single_op", operation, 1);
    chk("single_present", present, 1);
    chk("single_count", count, 1);
    core_in_valid = 1'b1;
    cyc();
    core_in_valid = 1'b0;
    chk("single_ret_present", present, 0);
    chk("single_ret_issued", issued, 1);
    chk("single_ret_idle", {i, j, k, operation}, 25'h1);

    // Underrun: accept with nothing presented
    core_in_valid = 1'b1;
    cyc();
    core_in_valid = 1'b0;
    chk("under_flag", underrun, 1);
    chk("under_issued", issued, 1);
    chk("under_present", present, 0);

    // Streaming 10 words at one per cycle
    do_reset();
    for (int n = 0; n < 10; n++) begin
      wr_en = 1'b1; wr_data = 25'($urandom);
      if (n >= 2) core_in_valid = 1'b1;
      cyc();
    end
    wr_en = 1'b0;
    repeat (2) cyc();
    core_in_valid = 1'b0;
    chk("stream_issued", issued, 10);
    chk("stream_underrun", underrun, 0);

    // Fill and overflow
    do_reset();
    for (int n = 0; n < 10; n++) begin
      wr_en = 1'b1; wr_data = 25'($urandom);
      cyc();
    end
    wr_en = 1'b0;
    cyc();
    chk("fill_count", count, 9);
    chk("fill_full", full, 1);
    chk("fill_overflow", overflow, 1);
    core_in_valid = 1'b1;
    repeat (12) cyc();
    core_in_valid = 1'b0;
    chk("drain_issued", issued, 9);
    chk("drain_present", present, 0);
    chk("drain_count", count, 0);

    // Mid-traffic reset flushes buffered words
    for (int n = 0; n < 6; n++) begin
      wr_en = 1'b1; wr_data = 25'($urandom);
      cyc();
    end
    do_reset();
    chk("flush_count", count, 0);
    chk("flush_operation", operation, 1);
    chk("flush_overflow", overflow, 0);
    repeat (3) cyc();
    chk("flush_present", present, 0);

    // Randomized traffic with varying write/accept bias and occasional reset
    for (int n = 0; n < 3000; n++) begin
      int wp, cp;
      wp = (n / 500) % 2 == 0 ? 70 : 35;
      cp = (n / 500) % 2 == 0 ? 40 : 75;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end
      wr_en = ($urandom_range(0, 99) < wp);
      wr_data = 25'($urandom);
      core_in_valid = ($urandom_range(0, 99) < cp);
      cyc();
    end
    wr_en = 1'b0; core_in_valid = 1'b0;

    // Issued counter wrap
    do_reset();
    for (int n = 0; n < 66000; n++) begin
      if (m_issued == 65537) break;
      wr_en = 1'b1; wr_data = 25'($urandom);
      core_in_valid = (n >= 2);
      cyc();
    end
    wr_en = 1'b0; core_in_valid = 1'b0;
    cyc();
    chk("wrap_issued", issued, 16'd1);
    chk("wrap_underrun", underrun, 0);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
